serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled on the rising edge.
REQ-005 SHALL have port a, input, WIDTH, minuend; sampled only on the edge that accepts start.
REQ-006 SHALL have port b, input, WIDTH, subtrahend; sampled only on the edge that accepts start.
REQ-007 SHALL have port borrow_in, input, 1, initial borrow; sampled only on the edge that accepts start.
REQ-008 SHALL have port busy, output, 1, high while bits are being processed.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-010 SHALL have port diff, output, WIDTH, result a - b - borrow_in modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out, output, 1, final borrow; 1 when a < b + borrow_in, unsigned.
REQ-012 SHALL have port zero, output, 1, high when diff equals 0.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE, held in registers.
REQ-014 SHALL, in IDLE with start=1, latch a, b and borrow_in, clear the bit counter, and enter RUN on the same edge.
REQ-015 SHALL ignore start whenever the state is RUN or DONE; no latch, no restart, no error.
REQ-016 SHALL, in RUN, process exactly one bit per edge, LSB first, at bit index i = counter value.
- d_i = a_i ^ b_i ^ bw
- bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw)
- bw is initialised from borrow_in.
REQ-017 SHALL shift or write d_i into diff bit i and store bw_next as the running borrow on each RUN edge.
REQ-018 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; there SHALL be no extra idle bit cycle.
REQ-019 SHALL, in DONE, drive done=1 for exactly one cycle, then return to IDLE on the next edge.
REQ-020 SHALL drive busy=1 exactly in RUN; busy and done SHALL never be high in the same cycle.
REQ-021 SHALL have a fixed latency: the accepting edge is edge 0; done is high in the cycle after edge WIDTH (WIDTH+1 edges from start to done).
REQ-022 SHALL update borrow_out and zero together with diff in the DONE cycle.
REQ-023 SHALL hold diff, borrow_out and zero stable from DONE until the edge that processes bit 0 of the next operation.
REQ-024 SHALL keep intermediate diff bits internal, or leave them don't-care while busy=1; verification checks diff only when done=1 or later in IDLE.
REQ-025 SHALL accept a new start in the IDLE cycle immediately following DONE, giving a minimum issue interval of WIDTH+2 cycles.
REQ-026 SHALL count the bit counter 0..WIDTH-1 with no wrap-around; counter width SHALL be clog2(WIDTH).
REQ-027 SHALL produce the result defined in REQ-010 and REQ-011, with every bit computed by the serial rule in REQ-016.
REQ-028 SHALL ignore changes on a, b and borrow_in after the accepting edge.

Reset
REQ-029 SHALL, when rst=1 on an edge, force:
- state to IDLE
- busy=0, done=0
- diff=0, borrow_out=0, zero=1
- counter and running borrow to 0
REQ-030 SHALL give rst priority over start and over all RUN/DONE activity, including reset mid-RUN; the partial result SHALL be discarded.
REQ-031 SHALL ignore start on the reset edge; the first start can be accepted on the edge after rst deasserts.

Verification
REQ-032 Basic: WIDTH=8, a=0x05, b=0x03, borrow_in=0 -> done 9 edges after start; diff=0x02, borrow_out=0, zero=0.
REQ-033 Underflow: a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1, zero=0.
REQ-034 Borrow chain and zero: first a=0x80, b=0x7F, borrow_in=1 -> diff=0x00, borrow_out=0, zero=1; then a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
REQ-035 Start ignored while busy: start pulsed with a=0xAA, b=0x55 in RUN cycle 3 -> original result unaffected, no second done, busy timing unchanged.
REQ-036 Reset mid-RUN: rst=1 at RUN cycle 4 -> next cycle busy=0, done=0, diff=0x00, zero=1; a new start then gives a correct result with full latency.
REQ-037 Back-to-back: start held high continuously with operands changing every cycle -> one done every 10 cycles, each result matching the operands sampled at its accepting edge.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing diff = a - b - borrow_in
// (mod 2^WIDTH), one bit per clock, LSB first.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - synchronous active-high reset
//   start      - begin a subtraction (accepted only in IDLE)
//   a, b       - minuend / subtrahend, latched on the accepting edge
//   borrow_in  - initial borrow, latched on the accepting edge
//   busy       - high while bits are being processed (RUN)
//   done       - one-cycle pulse, result valid (DONE)
//   diff       - result, updated on entry to DONE and held until the next
//                operation completes
//   borrow_out - final borrow (1 when a < b + borrow_in, unsigned)
//   zero       - high when diff == 0
//
// Latency: accepting edge is edge 0; bits 0..WIDTH-1 are processed on edges
// 1..WIDTH; done is high in the cycle after edge WIDTH.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Operand shift registers: bit 0 always holds operand bit i = cnt.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Partial result, filled from the top so bit 0 lands at the LSB after
  // WIDTH shifts. Kept internal so diff never shows intermediate bits.
  logic [WIDTH-1:0] acc;
  logic             bw;
  logic [CW-1:0]    cnt;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             bw_nx;
  logic             last;
  logic [WIDTH-1:0] acc_nx;

  // Single-bit full subtractor on the current bit position.
  always_comb begin
    a_i    = a_sr[0];
    b_i    = b_sr[0];
    d_i    = a_i ^ b_i ^ bw;
    bw_nx  = (~a_i & b_i) | (~(a_i ^ b_i) & bw);
    acc_nx = {d_i, acc[WIDTH-1:1]};
    last   = (cnt == LAST_BIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. start is only honoured in IDLE, so RUN/DONE ignore it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      acc        <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            bw   <= borrow_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          acc  <= acc_nx;
          bw   <= bw_nx;
          if (last) begin
            // Publish the complete result on the edge that processes the
            // final bit so it is visible in the DONE cycle.
            diff       <= acc_nx;
            borrow_out <= bw_nx;
            zero       <= (acc_nx == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer subtraction.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic bi,
                       output logic [7:0] d, output logic bo, output logic z);
    int r;
    r  = int'(x) - int'(y) - (bi ? 1 : 0);
    bo = (r < 0);
    if (r < 0) r += 256;
    d  = r[7:0];
    z  = (r == 0);
  endtask

  // Issue one operation from IDLE and check timing and result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] ed, input logic ebo, input logic ez,
                        input string nm);
    int lat;
    int busy_cnt;
    int overlap;
    start = 1'b1; a = ta; b = tb_; borrow_in = tbin;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
    lat = 0; busy_cnt = busy ? 1 : 0; overlap = 0;
    while (!done && lat < 3 * W) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
    end
    check({nm, "_latency"}, lat, W);
    check({nm, "_busy_cycles"}, busy_cnt, W);
    check({nm, "_overlap"}, overlap, 0);
    check({nm, "_diff"}, diff, ed);
    check({nm, "_borrow"}, borrow_out, ebo);
    check({nm, "_zero"}, zero, ez);
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, {busy, done}, 2'b00);
    check({nm, "_diff_hold"}, diff, ed);
  endtask

  logic [7:0] ra, rb, md;
  logic       rbin, mbo, mz;
  logic [7:0] qa[64];
  logic [7:0] qb[64];
  logic       qbin[64];
  int         dones;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

    // Reset with start held high: start must be ignored on reset edges.
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; borrow_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_diff", diff, 8'h00);
    check("reset_borrow", borrow_out, 1'b0);
    check("reset_zero", zero, 1'b1);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", {busy, done}, 2'b00);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].z,
             $sformatf("vec%0d", i));
    end

    // Randomized operations against the integer model.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      model(ra, rb, rbin, md, mbo, mz);
      run_op(ra, rb, rbin, md, mbo, mz, $sformatf("rand%0d", i));
    end

    // Start pulsed during RUN cycle 3 must be ignored.
    start = 1'b1; a = 8'h37; b = 8'h12; borrow_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    check("ign_busy_c3", busy, 1'b1);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 5; k < W; k++) begin
      @(posedge clk); #1;
    end
    check("ign_busy_last", {busy, done}, 2'b10);
    @(posedge clk); #1;
    check("ign_done", {busy, done}, 2'b01);
    check("ign_diff", diff, 8'h25);
    check("ign_borrow", borrow_out, 1'b0);
    dones = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("ign_no_second_op", dones, 0);

    // Reset asserted in RUN cycle 4 discards the partial result.
    start = 1'b1; a = 8'hC3; b = 8'h3C; borrow_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy_done", {busy, done}, 2'b00);
    check("midrst_diff", diff, 8'h00);
    check("midrst_zero", zero, 1'b1);
    check("midrst_borrow", borrow_out, 1'b0);
    dones = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op(8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0, "after_rst");

    // Back-to-back: start held high, operands changing every cycle.
    // Accepts land on edges 0, W+2, 2(W+2), ...; done follows W edges later.
    for (int c = 0; c < 64; c++) begin
      qa[c] = 8'($urandom); qb[c] = 8'($urandom); qbin[c] = 1'($urandom);
    end
    for (int c = 0; c < 50; c++) begin
      start = 1'b1; a = qa[c]; b = qb[c]; borrow_in = qbin[c];
      @(posedge clk); #1;
      check($sformatf("b2b_done_e%0d", c), done, ((c % (W + 2)) == W) ? 1'b1 : 1'b0);
      if ((c % (W + 2)) == W) begin
        model(qa[c - W], qb[c - W], qbin[c - W], md, mbo, mz);
        check($sformatf("b2b_diff_e%0d", c), diff, md);
        check($sformatf("b2b_borrow_e%0d", c), borrow_out, mbo);
        check($sformatf("b2b_zero_e%0d", c), zero, mz);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_final_idle", {busy, done}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
